// File: rtl/tff_counter_pkg.sv
// ---------------------------------------------------------------------------
// tff_counter_pkg
// Shared types and limits for the T-flip-flop counter/timer family.
//   timer_state_t   : down-timer FSM states (IDLE / RUN / DONE)
//   TIMER_WIDTH_MAX : largest supported counter width
// ---------------------------------------------------------------------------
package tff_counter_pkg;

    localparam int TIMER_WIDTH_MAX = 16;
    localparam int TIMER_WIDTH_MIN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage : tff_counter_pkg

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
// Single T flip-flop with a parallel-load override.
//   clk   : clock, rising edge
//   reset : asynchronous clear, active-high
//   t     : toggle enable
//   ld    : load enable (takes priority over t)
//   d     : value captured when ld is high
//   q     : flip-flop output
// ---------------------------------------------------------------------------
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule : tff_cell

// File: rtl/tff_down_timer.sv
// ---------------------------------------------------------------------------
// tff_down_timer
// Loadable synchronous down-counter/timer. Counts from a loaded value down to
// zero and pulses `done` for one cycle. All bits share `clk`; the decrement
// is built from a borrow chain of T cells, so `count` never glitches.
//
// Parameters:
//   WIDTH      : counter width, 2..16
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   load       : capture load_value into count (returns to IDLE)
//   load_value : value to load
//   start      : begin countdown from current count
//   stop       : abort countdown, count holds
//   count      : current counter value
//   busy       : high while in RUN
//   done       : one-cycle pulse when the countdown reaches zero
//
// Optional feature macro: TFF_DOWN_TIMER_AUTO_RELOAD_EN
//   When defined, a reload register captures every load and DONE reloads the
//   counter, restarting the countdown if the reload value is non-zero.
// ---------------------------------------------------------------------------
module tff_down_timer
    import tff_counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    if (WIDTH < TIMER_WIDTH_MIN || WIDTH > TIMER_WIDTH_MAX) begin : g_bad_width
        $error("tff_down_timer: WIDTH out of range 2..16");
    end

    timer_state_t     state_reg;
    timer_state_t     state_next;

    logic             count_is_zero;
    logic             count_is_one;
    logic             run_step;
    logic             cell_ld;
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] low_zero;   // low_zero[i]: bits [i-1:0] are all zero
    logic [WIDTH-1:0] toggle;

    assign count_is_zero = (count == '0);
    assign count_is_one  = (count == WIDTH'(1));

    // Decrement only in RUN and only when nothing of higher priority is
    // asserted; the zero guard makes wrap-around impossible even if the FSM
    // were ever to sit in RUN with a zero count.
    assign run_step = (state_reg == RUN) && !load && !stop && !count_is_zero;

`ifdef TFF_DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_reg <= '0;
        end else if (load) begin
            reload_reg <= load_value;
        end
    end
`endif

    // Parallel-load path shared by all cells.
    always_comb begin
        cell_ld = 1'b0;
        cell_d  = count;
        if (load) begin
            cell_ld = 1'b1;
            cell_d  = load_value;
        end
`ifdef TFF_DOWN_TIMER_AUTO_RELOAD_EN
        else if (state_reg == DONE && !stop) begin
            cell_ld = 1'b1;
            cell_d  = reload_reg;
        end
`endif
    end

    // Borrow chain: bit 0 always toggles on a decrement, bit i toggles when
    // every lower bit is zero (i.e. it has to lend).
    assign low_zero[0] = 1'b1;

    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_borrow
        assign low_zero[gi] = low_zero[gi-1] & ~count[gi-1];
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        assign toggle[gi] = run_step & low_zero[gi];

        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (toggle[gi]),
            .ld    (cell_ld),
            .d     (cell_d[gi]),
            .q     (count[gi])
        );
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; priority load > stop > start > decrement.
    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (!stop && start) begin
                        state_next = count_is_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = IDLE;
                    end else if (count_is_one || count_is_zero) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
`ifdef TFF_DOWN_TIMER_AUTO_RELOAD_EN
                    if (stop || reload_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RUN;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
    end

endmodule : tff_down_timer
